mux_4x1: RTL and testbench



---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_4x1_comb.sv | 26 ++
 rtl/mux_4x1.sv | 45 ++++
 tb/tb_mux_4x1.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select-code definitions for the 4-to-1 multiplexer family.
package mux_pkg;

    typedef enum logic [1:0] {
        SEL_IN0 = 2'b00,
        SEL_IN1 = 2'b01,
        SEL_IN2 = 2'b10,
        SEL_IN3 = 2'b11
    } sel_e;

endpackage

// File: rtl/mux_4x1_comb.sv
// Purely combinational WIDTH-bit 4-to-1 select; bit i of y comes only from bit i of the chosen input.
module mux_4x1_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel_e'(sel))
            SEL_IN0: y = in0;
            SEL_IN1: y = in1;
            SEL_IN2: y = in2;
            SEL_IN3: y = in3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux_4x1.sv
// Registered 4-to-1 multiplexer: one-cycle latency, output holds between valid cycles.
module mux_4x1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] selected;

    mux_4x1_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
        .sel(sel),
        .y  (selected)
    );

    // Data register loads only on valid cycles, so an undriven sel while idle never reaches state.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= selected;
            end
        end
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Scoreboard bench for mux_4x1 at WIDTH=7 and WIDTH=1.
module tb_mux_4x1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=7 instance
    logic       rst7 = 1'b1, vld7 = 1'b0;
    logic [6:0] a7 = '0, b7 = '0, c7 = '0, d7 = '0;
    logic [1:0] sel7 = '0;
    logic [6:0] out7;
    logic       ov7;

    // WIDTH=1 instance
    logic       rst1 = 1'b1, vld1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, d1 = 1'b0;
    logic [1:0] sel1 = '0;
    logic       out1;
    logic       ov1;

    mux_4x1 #(.WIDTH(7)) dut7 (
        .clk(clk), .reset(rst7), .in_valid(vld7),
        .in0(a7), .in1(b7), .in2(c7), .in3(d7), .sel(sel7),
        .out(out7), .out_valid(ov7)
    );

    mux_4x1 #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(rst1), .in_valid(vld1),
        .in0(a1), .in1(b1), .in2(c1), .in3(d1), .sel(sel1),
        .out(out1), .out_valid(ov1)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [7:0] q7[$];
    logic [1:0] q1[$];
    logic [6:0] m_out7 = '0;
    logic       m_ov7  = 1'b0;
    logic       m_out1 = 1'b0;
    logic       m_ov1  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock for the 7-bit instance: drive, model the edge, push expectation, pop and compare.
    task automatic cyc7(input string tag, input logic r, input logic v, input logic [1:0] s,
                        input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        logic [6:0] ins [4];
        logic [7:0] e;
        rst7 = r; vld7 = v; sel7 = s; a7 = a; b7 = b; c7 = c; d7 = d;
        ins[0] = a; ins[1] = b; ins[2] = c; ins[3] = d;
        @(posedge clk);
        if (r) begin
            m_out7 = '0; m_ov7 = 1'b0;
        end else if (v) begin
            m_out7 = ins[s]; m_ov7 = 1'b1;
        end else begin
            m_ov7 = 1'b0;
        end
        q7.push_back({m_out7, m_ov7});
        #1;
        e = q7.pop_front();
        check({tag, ".out"}, 32'(out7), 32'(e[7:1]));
        check({tag, ".vld"}, 32'(ov7), 32'(e[0]));
    endtask

    task automatic cyc1(input string tag, input logic r, input logic v, input logic [1:0] s,
                        input logic [3:0] ins);
        logic [1:0] e;
        rst1 = r; vld1 = v; sel1 = s; a1 = ins[0]; b1 = ins[1]; c1 = ins[2]; d1 = ins[3];
        @(posedge clk);
        if (r) begin
            m_out1 = 1'b0; m_ov1 = 1'b0;
        end else if (v) begin
            m_out1 = ins[s]; m_ov1 = 1'b1;
        end else begin
            m_ov1 = 1'b0;
        end
        q1.push_back({m_out1, m_ov1});
        #1;
        e = q1.pop_front();
        check({tag, ".out"}, 32'(out1), 32'(e[1]));
        check({tag, ".vld"}, 32'(ov1), 32'(e[0]));
    endtask

    initial begin
        // Reset dominates a valid all-ones input
        for (int i = 0; i < 2; i++)
            cyc7("rst", 1'b1, 1'b1, 2'b11, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // Full decode, back-to-back
        for (int i = 0; i < 4; i++)
            cyc7("dec", 1'b0, 1'b1, 2'(i), 7'b1000001, 7'b1100011, 7'b1110111, 7'b1111001);

        // Hold with in_valid low, sel moved to 00
        for (int i = 0; i < 2; i++)
            cyc7("hold", 1'b0, 1'b0, 2'b00, 7'b1000001, 7'b1100011, 7'b1110111, 7'b1111001);

        // Input change between edges must not reach out
        a7 = 7'h00; b7 = 7'h55; sel7 = 2'b01; vld7 = 1'b1;
        #2;
        check("nocomb.out", 32'(out7), 32'(m_out7));
        check("nocomb.vld", 32'(ov7), 32'(m_ov7));

        // Bit independence
        for (int i = 0; i < 6; i++)
            cyc7("bits", 1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10,
                 7'h2A, 7'b0111111, 7'b1000000, 7'h15);

        // Mid-stream reset
        for (int i = 0; i < 2; i++)
            cyc7("pre", 1'b0, 1'b1, 2'b11, 7'h01, 7'h02, 7'h04, 7'b1111110);
        cyc7("midrst", 1'b1, 1'b1, 2'b11, 7'h01, 7'h02, 7'h04, 7'b1111110);
        cyc7("post", 1'b0, 1'b1, 2'b11, 7'h01, 7'h02, 7'h04, 7'b1111110);

        // Random traffic
        for (int i = 0; i < 40; i++)
            cyc7("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));

        // Scalar width
        cyc1("rst1", 1'b1, 1'b1, 2'b01, 4'b0110);
        for (int i = 0; i < 4; i++)
            cyc1("w1", 1'b0, 1'b1, 2'(i), 4'b0110);
        cyc1("hold1", 1'b0, 1'b0, 2'b00, 4'b0110);
        for (int i = 0; i < 16; i++)
            cyc1("rnd1", 1'b0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
